// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack slave bus among NREQ masters.
// Optional XFER watchdog (err pulse, RECOVER state) enabled by BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         m_req,
  input  logic [NREQ-1:0]         m_rw,
  input  logic [NREQ*DW-1:0]      m_wdata,
  output logic [NREQ-1:0]         m_gnt,
  output logic [NREQ-1:0]         m_ack,
  output logic [DW-1:0]           m_rdata,
  output logic                    s_req,
  output logic                    s_rw,
  output logic [DW-1:0]           s_wdata,
  input  logic                    s_ack,
  input  logic [DW-1:0]           s_rdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    err
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic [OW-1:0]   owner_q, owner_d, ptr_q, ptr_d;
  logic [OW-1:0]   win, cand;
  logic            found;
  logic            busy_q, busy_d, sreq_q, sreq_d, srw_q, srw_d;
  logic [DW-1:0]   swdata_q, swdata_d, rdata_q, rdata_d;
  logic            ack_meta_q, ack_s_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Round-robin search starting just above the last owner.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(ptr_q) + k) % NREQ);
      if (!found && m_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    sreq_d   = sreq_q;
    srw_d    = srw_q;
    swdata_d = swdata_q;
    rdata_d  = rdata_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Holding off while ack_s is still high enforces the return-to-zero phase.
        if (found && !ack_s_q) begin
          state_d    = XFER;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          busy_d     = 1'b1;
          sreq_d     = 1'b1;
          srw_d      = m_rw[win];
          swdata_d   = m_wdata[int'(win)*DW +: DW];
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      XFER: begin
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d = cnt_q + 4'd1;
`endif
        if (ack_s_q) begin
          if (srw_q) rdata_d = s_rdata;
          ack_d[owner_q] = 1'b1;
          sreq_d         = 1'b0;
          state_d        = RELEASE;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (cnt_d == 4'hF) begin
          err_d   = 1'b1;
          sreq_d  = 1'b0;
          gnt_d   = '0;
          ptr_d   = owner_q;
          state_d = RECOVER;
        end
`endif
      end
      RELEASE: begin
        if (!ack_s_q && !m_req[owner_q]) begin
          ack_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q;
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (!ack_s_q && !m_req[owner_q]) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= OW'(NREQ - 1);
      busy_q     <= 1'b0;
      sreq_q     <= 1'b0;
      srw_q      <= 1'b0;
      swdata_q   <= '0;
      rdata_q    <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      sreq_q     <= sreq_d;
      srw_q      <= srw_d;
      swdata_q   <= swdata_d;
      rdata_q    <= rdata_d;
      ack_meta_q <= s_ack;
      ack_s_q    <= ack_meta_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign m_gnt   = gnt_q;
  assign m_ack   = ack_q;
  assign m_rdata = rdata_q;
  assign s_req   = sreq_q;
  assign s_rw    = srw_q;
  assign s_wdata = swdata_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: write, read, contention, early drop, reset, timeout.
module tb_bus_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         m_req = '0;
  logic [NREQ-1:0]         m_rw = '0;
  logic [NREQ*DW-1:0]      m_wdata = '0;
  logic [NREQ-1:0]         m_gnt, m_ack;
  logic [DW-1:0]           m_rdata;
  logic                    s_req, s_rw;
  logic [DW-1:0]           s_wdata;
  logic                    s_ack = 1'b0;
  logic [DW-1:0]           s_rdata = '0;
  logic                    busy, err;
  logic [$clog2(NREQ)-1:0] owner;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_rw(s_rw), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(m_gnt), 0);
    chk({tag, "_ack"}, 32'(m_ack), 0);
    chk({tag, "_sreq"}, 32'(s_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, 32'(m_rdata), 0);
    chk({tag, "_swdata"}, 32'(s_wdata), 0);
  endtask

  // Full handshake for master m; the request must already be raised.
  task automatic do_xfer(input int m, input bit rw, input logic [DW-1:0] rd, input bit rereq);
    int n;
    n = 0;
    while (m_gnt == '0 && n < 8) begin tick(); n++; end
    chk("grant", 32'(m_gnt), 1 << m);
    chk("owner", 32'(owner), m);
    chk("s_req_set", 32'(s_req), 1);
    chk("s_rw", 32'(s_rw), 32'(rw));
    chk("s_wdata", 32'(s_wdata), 32'(m_wdata[m*DW +: DW]));
    s_rdata = rd;
    s_ack   = 1'b1;
    n = 0;
    while (m_ack == '0 && n < 8) begin tick(); n++; end
    chk("ack_latency_2to3", 32'(n >= 2 && n <= 3), 1);
    chk("m_ack", 32'(m_ack), 1 << m);
    chk("s_req_drop", 32'(s_req), 0);
    chk("grant_held", 32'(m_gnt), 1 << m);
    if (rw) chk("m_rdata", 32'(m_rdata), 32'(rd));
    s_ack    = 1'b0;
    m_req[m] = 1'b0;
    n = 0;
    while (busy && n < 8) begin tick(); n++; end
    chk("grant_clear", 32'(m_gnt), 0);
    chk("ack_clear", 32'(m_ack), 0);
    if (rereq) m_req[m] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, errs, first, acks;
    logic prev;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset");

    // Single write from master 0
    rst     = 1'b0;
    m_wdata = 16'h432F;
    m_req   = 4'b0001;
    do_xfer(0, 1'b0, 4'h0, 1'b0);

    // Single read from master 2, then a write that must leave m_rdata alone
    m_rw  = 4'b0100;
    m_req = 4'b0100;
    do_xfer(2, 1'b1, 4'hA, 1'b0);
    m_rw  = 4'b0000;
    m_req = 4'b1000;
    do_xfer(3, 1'b0, 4'h5, 1'b0);
    chk("rdata_hold", 32'(m_rdata), 32'hA);

    // Contention right after reset: 0,1,2,3,0
    rst   = 1'b1;
    m_req = 4'b1111;
    tick(); tick();
    rst = 1'b0;
    do_xfer(0, 1'b0, 4'h0, 1'b1);
    do_xfer(1, 1'b0, 4'h0, 1'b1);
    do_xfer(2, 1'b0, 4'h0, 1'b1);
    do_xfer(3, 1'b0, 4'h0, 1'b1);
    do_xfer(0, 1'b0, 4'h0, 1'b0);
    m_req = 4'b0000;
    tick();
    chk("idle_after_contention", 32'(m_gnt), 0);

    // Master 1 drops its request mid-transfer
    m_req = 4'b0010;
    n = 0;
    while (m_gnt == '0 && n < 8) begin tick(); n++; end
    chk("drop_grant", 32'(m_gnt), 32'b0010);
    m_req[1] = 1'b0;
    repeat (5) tick();
    chk("drop_sreq_held", 32'(s_req), 1);
    chk("drop_busy_held", 32'(busy), 1);
    s_ack  = 1'b1;
    pulses = 0;
    prev   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_ack[1] && !prev) pulses++;
      prev = m_ack[1];
      if (m_ack[1]) s_ack = 1'b0;
    end
    chk("drop_one_ack_pulse", 32'(pulses), 1);
    chk("drop_released", 32'(busy), 0);

    // Reset during XFER of master 2; master 0 must win afterwards
    m_req = 4'b0101;
    n = 0;
    while (m_gnt == '0 && n < 8) begin tick(); n++; end
    chk("pre_reset_grant", 32'(m_gnt), 32'b0100);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    rst = 1'b0;
    do_xfer(0, 1'b0, 4'h0, 1'b0);
    do_xfer(2, 1'b0, 4'h0, 1'b0);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Slave never answers master 0; master 1 is waiting behind it
    m_req = 4'b0011;
    n = 0;
    while (m_gnt == '0 && n < 8) begin tick(); n++; end
    chk("tmo_grant", 32'(m_gnt), 32'b0001);
    errs  = 0;
    first = -1;
    acks  = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (m_ack != '0) acks++;
      if (err) begin
        errs++;
        if (first < 0) first = i;
        chk("tmo_gnt_clear", 32'(m_gnt), 0);
        chk("tmo_sreq_clear", 32'(s_req), 0);
        m_req[0] = 1'b0;
      end
    end
    chk("tmo_err_count", 32'(errs), 1);
    chk("tmo_err_cycle", 32'(first), 15);
    chk("tmo_no_ack", 32'(acks), 0);
    do_xfer(1, 1'b0, 4'h0, 1'b0);
`else
    // Without the watchdog the transfer waits indefinitely
    m_req = 4'b0001;
    n = 0;
    while (m_gnt == '0 && n < 8) begin tick(); n++; end
    chk("wait_grant", 32'(m_gnt), 32'b0001);
    errs = 0;
    repeat (40) begin
      tick();
      if (err) errs++;
    end
    chk("wait_no_err", 32'(errs), 0);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_sreq", 32'(s_req), 1);
    do_xfer(0, 1'b0, 4'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001: Parameter NREQ, default 4, SHALL set the number of requesting masters (2..8).
REQ-002: Parameter DW, default 4, SHALL set the data width of the shared req/ack bus.
REQ-003: Clocking SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006: m_req  input  NREQ  SHALL carry the per-master transfer request, level, 4-phase.
REQ-007: m_rw  input  NREQ  SHALL carry the per-master direction: 1 = read, 0 = write.
REQ-008: m_wdata  input  NREQ*DW  SHALL carry per-master write data; master i occupies bits [i*DW +: DW].
REQ-009: m_gnt  output  NREQ  SHALL be a one-hot grant, or all zero.
REQ-010: m_ack  output  NREQ  SHALL be the per-master acknowledge, asserted only to the owner.
REQ-011: m_rdata  output  DW  SHALL be the read data returned to the owner, valid while m_ack is high.
REQ-012: s_req, s_rw, s_wdata  output  1/1/DW  SHALL drive the shared slave-side request, direction and write data.
REQ-013: s_ack  input  1  SHALL be the slave acknowledge; it is asynchronous to clk.
REQ-014: s_rdata  input  DW  SHALL be the slave read data, stable while s_ack is high.
REQ-015: busy, owner, err  output  1/clog2(NREQ)/1  SHALL indicate a transfer in progress, the granted index, and the timeout pulse.

Function
REQ-016: s_ack SHALL pass through a 2-flop synchronizer (ack_s); only ack_s is used internally.
REQ-017: The FSM SHALL have states IDLE, XFER, RELEASE and RECOVER.
REQ-018: In IDLE with any m_req bit high, the winner SHALL be the first requester found searching upward from (ptr+1) mod NREQ, with wrap-around.
REQ-019: In the cycle after m_req is sampled, the block SHALL set m_gnt[w], owner=w, busy=1 and s_req=1, latch s_rw=m_rw[w] and s_wdata=m_wdata[w], and enter XFER.
REQ-020: s_rw and s_wdata SHALL hold constant from grant until RELEASE exits.
REQ-021: In XFER on ack_s=1, the block SHALL latch m_rdata=s_rdata when s_rw=1 (hold the previous value otherwise), set m_ack[owner]=1 and s_req=0, and enter RELEASE.
REQ-022: In RELEASE, when ack_s=0 and m_req[owner]=0, the block SHALL clear m_ack, m_gnt and busy, set ptr=owner, and return to IDLE.
REQ-023: Minimum transfer time SHALL be 1 grant cycle, plus 2 synchronizer cycles, plus the slave and master handshake times.
REQ-024: A deassertion of m_req[owner] during XFER SHALL be ignored; the slave handshake always completes.
REQ-025: Requests from non-owners SHALL wait without loss; the block SHALL not preempt the owner.
REQ-026: Every requester SHALL be granted within NREQ transfers while its m_req is held high.
REQ-027: A new grant SHALL NOT be issued while ack_s=1, which guarantees a 4-phase return to zero.
REQ-028: After RELEASE, the block SHALL spend at least one cycle in IDLE before the next grant.

Reset
REQ-029: While rst=1, all outputs SHALL be 0, the state SHALL be IDLE, ptr SHALL be NREQ-1 so that master 0 has first priority, and the synchronizer and timeout counter SHALL be cleared.
REQ-030: A reset asserted mid-transfer SHALL drop s_req, m_gnt and m_ack on the next edge; the slave is not waited on.

Configuration
REQ-031: With macro BUS_ARBITER_TIMEOUT_EN defined, a 4-bit counter SHALL count cycles in XFER.
REQ-032: With BUS_ARBITER_TIMEOUT_EN defined and the count reaching 15 with ack_s=0, the block SHALL pulse err=1 for one cycle, clear s_req and m_gnt (m_ack never asserted), set ptr=owner, and enter RECOVER.
REQ-033: The block SHALL leave RECOVER for IDLE when ack_s=0 and m_req[owner]=0.
REQ-034: Without BUS_ARBITER_TIMEOUT_EN, err SHALL be tied to 0, RECOVER SHALL be unreachable, and XFER SHALL wait indefinitely.

Verification
REQ-035: The bench SHALL cover a single write: m_req=0001, m_rw[0]=0, m_wdata[0]=4'hF, giving m_gnt=0001 and s_req=1 with s_wdata=F one cycle later, and m_ack[0] 2-3 cycles after s_ack rises.
REQ-036: The bench SHALL cover a single read: master 2 with s_rdata=4'hA, giving m_rdata=A while m_ack[2]=1.
REQ-037: The bench SHALL cover contention: m_req=1111 held after reset, giving grant order 0,1,2,3,0 with no grant overlap.
REQ-038: The bench SHALL cover an early drop: master 1 drops m_req during XFER, and s_req still waits for s_ack, with exactly one m_ack[1] pulse.
REQ-039: The bench SHALL cover reset mid-XFER: all outputs are 0 the next cycle, and the next grant after release goes to master 0.
REQ-040: The bench SHALL cover timeout with BUS_ARBITER_TIMEOUT_EN defined: s_ack is never asserted, err pulses exactly once 15 cycles into XFER, and the next requester is then granted.
